roi_scan_ctrl: RTL and testbench

- Serial scan harness that sits between the chip pins and the fuzzer ROI.
- Loads a DIN_N-bit stimulus frame serially and applies it to the ROI as one parallel word.
- Waits a fixed settle time, captures the ROI's DOUT_N-bit response, then shifts the response out serially.
- Replaces the free-running strobe-driven shifters with a self-timed, counted frame protocol, so the bench knows exactly when data is valid.

---
 rtl/roi_scan_ctrl_if.sv | 40 ++++
 rtl/roi_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_roi_scan_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/roi_scan_ctrl_if.sv
// Scan-side bundle for roi_scan_ctrl: serial in/out, status, and the ROI word pair.
// slave = the controller, master = the pins/bench and ROI that drive it.
interface roi_scan_ctrl_if #(
   parameter int DIN_N  = 256,
   parameter int DOUT_N = 256
);
   logic              i_di;
   logic              i_di_valid;
   logic [DIN_N-1:0]  o_din;
   logic [DOUT_N-1:0] i_dout;
   logic              o_do;
   logic              o_do_valid;
   logic              o_busy;
   logic              o_frame_done;
   logic              o_overrun;

   modport slave (
      input  i_di,
      input  i_di_valid,
      input  i_dout,
      output o_din,
      output o_do,
      output o_do_valid,
      output o_busy,
      output o_frame_done,
      output o_overrun
   );

   modport master (
      output i_di,
      output i_di_valid,
      output i_dout,
      input  o_din,
      input  o_do,
      input  o_do_valid,
      input  o_busy,
      input  o_frame_done,
      input  o_overrun
   );
endinterface

// File: rtl/roi_scan_ctrl.sv
// Self-timed scan harness: serial stimulus in, parallel apply, settle,
// capture, serial response out. Ports: clk, rst_n (async low), bus (slave).
module roi_scan_ctrl #(
   parameter int DIN_N  = 256,
   parameter int DOUT_N = 256,
   parameter int SETTLE = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   roi_scan_ctrl_if.slave bus
);
   localparam int BW = $clog2(DIN_N + 1);
   localparam int OW = $clog2(DOUT_N);
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(DIN_N - 1);
   localparam logic [OW-1:0] OUT_LAST = OW'(DOUT_N - 1);
   localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

   localparam logic [2:0] ST_SHIFT   = 3'd0;
   localparam logic [2:0] ST_APPLY   = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_UNLOAD  = 3'd4;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nx;
   logic [BW-1:0]     r_bcnt;
   logic [SW-1:0]     r_scnt;
   logic [OW-1:0]     r_ocnt;
   logic [DIN_N-1:0]  r_din_shr;
   logic [DIN_N-1:0]  r_din;
   logic [DOUT_N-1:0] r_out_shr;
   logic              r_do;
   logic              r_do_valid;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_overrun;

   logic w_accept;
   logic w_drop;
   logic w_bit_last;
   logic w_set_last;
   logic w_out_last;

   assign w_accept   = bus.i_di_valid && (r_state == ST_SHIFT);
   assign w_drop     = bus.i_di_valid && (r_state != ST_SHIFT);
   assign w_bit_last = (r_bcnt == BIT_LAST);
   assign w_set_last = (r_scnt == SET_LAST);
   assign w_out_last = (r_ocnt == OUT_LAST);

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         ST_SHIFT: begin
            if (w_accept && w_bit_last) w_state_nx = ST_APPLY;
         end
         ST_APPLY: begin
            w_state_nx = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;
         end
         ST_SETTLE: begin
            if (w_set_last) w_state_nx = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_state_nx = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            if (w_out_last) w_state_nx = ST_SHIFT;
         end
         default: begin
            w_state_nx = ST_SHIFT;
         end
      endcase
   end

   // busy follows the state register so it is glitch-free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_SHIFT;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_busy  <= (w_state_nx != ST_SHIFT);
      end
   end

   // first bit received ends up in the MSB after DIN_N shifts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din_shr <= '0;
         r_bcnt    <= '0;
      end else if (w_accept) begin
         r_din_shr <= {r_din_shr[DIN_N-2:0], bus.i_di};
         r_bcnt    <= w_bit_last ? '0 : r_bcnt + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din <= '0;
      end else if (r_state == ST_APPLY) begin
         r_din <= r_din_shr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scnt <= '0;
      end else if (r_state == ST_SETTLE) begin
         r_scnt <= w_set_last ? '0 : r_scnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_shr    <= '0;
         r_ocnt       <= '0;
         r_do         <= 1'b0;
         r_do_valid   <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (r_state == ST_CAPTURE) begin
         r_out_shr    <= bus.i_dout;
         r_ocnt       <= '0;
         r_do         <= 1'b0;
         r_do_valid   <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (r_state == ST_UNLOAD) begin
         r_do         <= r_out_shr[DOUT_N-1];
         r_out_shr    <= {r_out_shr[DOUT_N-2:0], 1'b0};
         r_do_valid   <= 1'b1;
         r_frame_done <= w_out_last;
         r_ocnt       <= w_out_last ? '0 : r_ocnt + OW'(1);
      end else begin
         r_do         <= 1'b0;
         r_do_valid   <= 1'b0;
         r_frame_done <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end
   end

   assign bus.o_din        = r_din;
   assign bus.o_do         = r_do;
   assign bus.o_do_valid   = r_do_valid;
   assign bus.o_busy       = r_busy;
   assign bus.o_frame_done = r_frame_done;
   assign bus.o_overrun    = r_overrun;
endmodule

// File: tb/tb_roi_scan_ctrl.sv
// Bench for roi_scan_ctrl: loopback instance (SETTLE=4) and constant-response
// instance (SETTLE=0) driven by one stimulus, checked against a timeline model.
module tb_roi_scan_ctrl;
   localparam int N  = 256;
   localparam int S0 = 4;
   localparam int S1 = 0;
   localparam logic [N-1:0] A5 = {32{8'hA5}};

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic s_di = 1'b0;
   logic s_dv = 1'b0;

   always #5 clk = ~clk;

   roi_scan_ctrl_if #(.DIN_N(N), .DOUT_N(N)) bus_a ();
   roi_scan_ctrl_if #(.DIN_N(N), .DOUT_N(N)) bus_b ();

   assign bus_a.i_di       = s_di;
   assign bus_a.i_di_valid = s_dv;
   assign bus_a.i_dout     = bus_a.o_din;
   assign bus_b.i_di       = s_di;
   assign bus_b.i_di_valid = s_dv;
   assign bus_b.i_dout     = A5;

   roi_scan_ctrl #(.DIN_N(N), .DOUT_N(N), .SETTLE(S0)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   roi_scan_ctrl #(.DIN_N(N), .DOUT_N(N), .SETTLE(S1)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // model: per instance, the edge index of the last accepted frame bit
   // fixes the whole output timeline of that frame
   longint     e = 0;
   longint     t_end [2];
   int         m_cnt [2];
   int         sv [2] = '{S0, S1};
   logic [N-1:0] m_acc [2];
   logic [N-1:0] m_word [2];
   logic [N-1:0] m_din [2];
   logic [N-1:0] m_cap [2];
   bit         m_ovr [2];

   function automatic void mreset();
      for (int k = 0; k < 2; k++) begin
         t_end[k]  = -1000000;
         m_cnt[k]  = 0;
         m_acc[k]  = '0;
         m_word[k] = '0;
         m_din[k]  = '0;
         m_cap[k]  = '0;
         m_ovr[k]  = 1'b0;
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mreset();
         end else begin
            e++;
            for (int k = 0; k < 2; k++) begin
               if (e == t_end[k] + 1) m_din[k] = m_word[k];
               if (s_dv) begin
                  if (e <= t_end[k] + 2 + sv[k] + N) begin
                     m_ovr[k] = 1'b1;
                  end else begin
                     m_acc[k][N-1-m_cnt[k]] = s_di;
                     m_cnt[k]++;
                     if (m_cnt[k] == N) begin
                        m_cnt[k]  = 0;
                        t_end[k]  = e;
                        m_word[k] = m_acc[k];
                        m_cap[k]  = (k == 0) ? m_acc[k] : A5;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic cmp(input int k, input logic [N-1:0] din,
                      input logic dv, input logic dob, input logic busy,
                      input logic fd, input logic ovr);
      longint s;
      logic   xdv;
      int     idx;
      s   = t_end[k] + longint'(sv[k]);
      xdv = (e >= s + 3) && (e <= s + 2 + N);
      chk($sformatf("din_%0d", k), din, m_din[k]);
      chk($sformatf("busy_%0d", k), busy,
          (e >= t_end[k]) && (e <= s + 1 + N));
      chk($sformatf("do_valid_%0d", k), dv, xdv);
      chk($sformatf("frame_done_%0d", k), fd, e == s + 2 + N);
      chk($sformatf("overrun_%0d", k), ovr, m_ovr[k]);
      if (xdv) begin
         idx = int'(longint'(N - 1) - (e - (s + 3)));
         chk($sformatf("do_%0d", k), dob, m_cap[k][idx]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cmp(0, bus_a.o_din, bus_a.o_do_valid, bus_a.o_do,
             bus_a.o_busy, bus_a.o_frame_done, bus_a.o_overrun);
         cmp(1, bus_b.o_din, bus_b.o_do_valid, bus_b.o_do,
             bus_b.o_busy, bus_b.o_frame_done, bus_b.o_overrun);
      end
   end

   logic qa [$];
   logic qb [$];
   int   fd_a = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (bus_a.o_do_valid) qa.push_back(bus_a.o_do);
         if (bus_b.o_do_valid) qb.push_back(bus_b.o_do);
         if (bus_a.o_frame_done) fd_a++;
      end
   end

   task automatic cyc(input logic v, input logic b);
      s_dv = v;
      s_di = b;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] qa_word();
      logic [N-1:0] w;
      w = '0;
      for (int i = 0; i < N && i < qa.size(); i++) w[N-1-i] = qa[i];
      return w;
   endfunction

   logic [N-1:0] sent;
   logic [7:0]   b8;
   int           lat_a;
   int           lat_b;
   logic         rb;

   initial begin
      mreset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus_a.o_busy, 0);
      chk("rst_dv", bus_a.o_do_valid, 0);
      chk("rst_din", bus_a.o_din, 0);
      chk("rst_ovr", bus_a.o_overrun, 0);
      rst_n = 1'b1;

      // frame 1: bit i = (i%3==0), contiguous
      for (int i = 0; i < N; i++) begin
         rb = (i % 3 == 0);
         sent[N-1-i] = rb;
         cyc(1'b1, rb);
      end
      chk("busy_after_last", bus_a.o_busy, 1);
      chk("din_before_apply", bus_a.o_din, 0);
      cyc(1'b0, 1'b0);
      chk("din_top4", bus_a.o_din[N-1 -: 4], 4'b1001);
      lat_a = 0;
      lat_b = 0;
      for (int n = 2; n <= 20; n++) begin
         cyc(1'b0, 1'b0);
         if (lat_a == 0 && bus_a.o_do_valid) lat_a = n;
         if (lat_b == 0 && bus_b.o_do_valid) lat_b = n;
      end
      chk("latency_a", lat_a, 7);
      chk("latency_b", lat_b, 3);
      b8 = '0;
      for (int i = 0; i < 8 && i < qb.size(); i++) b8[7-i] = qb[i];
      chk("a5_stream", b8, 8'hA5);
      repeat (300) cyc(1'b0, 1'b0);
      chk("loop_len", qa.size(), N);
      chk("loop_stream", qa_word(), sent);
      chk("fd_count", fd_a, 1);
      chk("busy_idle", bus_a.o_busy, 0);

      // frame 2: di_valid every other cycle
      qa.delete();
      for (int i = 0; i < N; i++) begin
         rb = 1'($urandom());
         sent[N-1-i] = rb;
         cyc(1'b1, rb);
         cyc(1'b0, 1'($urandom()));
      end
      repeat (300) cyc(1'b0, 1'b0);
      chk("gap_din", bus_a.o_din, sent);
      chk("gap_stream", qa_word(), sent);
      chk("gap_ovr", bus_a.o_overrun, 0);

      // frame 3: di_valid held high through the busy window
      for (int i = 0; i < N; i++) cyc(1'b1, 1'($urandom()));
      repeat (280) cyc(1'b1, 1'($urandom()));
      chk("ovr_set", bus_a.o_overrun, 1);
      repeat (300) cyc(1'b0, 1'b0);
      chk("ovr_sticky", bus_a.o_overrun, 1);

      // frame 4: reset in the middle of the unload
      qa.delete();
      for (int i = 0; i < N; i++) cyc(1'b1, 1'($urandom()));
      for (int n = 0; n < 600 && qa.size() < 100; n++) cyc(1'b0, 1'b0);
      chk("unload_reached", qa.size() >= 100, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_dv", bus_a.o_do_valid, 0);
      chk("mid_rst_busy", bus_a.o_busy, 0);
      chk("mid_rst_din", bus_a.o_din, 0);
      chk("mid_rst_ovr", bus_a.o_overrun, 0);
      chk("mid_rst_dv_b", bus_b.o_do_valid, 0);
      repeat (3) cyc(1'b0, 1'b0);
      rst_n = 1'b1;

      // random traffic after release
      for (int n = 0; n < 1200; n++) cyc(1'($urandom()), 1'($urandom()));
      repeat (700) cyc(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
